// File: rtl/shift_load_sequencer.sv
// Round-robin front end for a serial-in shift register: grants one requester's word,
// shifts it MSB-first over SR_LOAD/SR_DATA, then reads SR_Q back and reports completion.
module shift_load_sequencer #(
  parameter int WIDTH       = 4,
  parameter int NREQ        = 2,
  parameter int HOLD_CYCLES = 2,
  localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET_B,
  input  logic [NREQ-1:0]       REQ_VALID,
  input  logic [NREQ*WIDTH-1:0] REQ_DATA,
  output logic [NREQ-1:0]       REQ_READY,
  output logic                  SR_LOAD,
  output logic                  SR_DATA,
  input  logic [WIDTH-1:0]      SR_Q,
  output logic                  DONE,
  output logic [IDW-1:0]        DONE_ID,
  output logic                  MISMATCH,
  output logic                  BUSY
);

  localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(WIDTH - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, HOLD} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_vld;
  logic [IDW-1:0]   gnt_p0;
  logic [CW-1:0]    bit_cnt;
  logic [HCW-1:0]   hold_cnt;
  logic [WIDTH-1:0] req_word;
  logic [WIDTH-1:0] word_p0;
  logic [WIDTH-1:0] shreg_p0;
  logic [WIDTH-1:0] shreg_nxt;

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] idx);
    if (int'(idx) >= NREQ - 1)
      return '0;
    else
      return idx + IDW'(1);
  endfunction

  // Arbitration: first valid requester at or after the round-robin pointer.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = int'(ptr) + k;
      if (i >= NREQ)
        i = i - NREQ;
      if (!gnt_vld && REQ_VALID[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end

  assign req_word = REQ_DATA[int'(gnt_idx)*WIDTH +: WIDTH];

  // Ready is gated by RESET_B so it drops the moment reset asserts.
  always_comb begin
    REQ_READY = '0;
    if (RESET_B && (state == IDLE) && gnt_vld)
      REQ_READY[gnt_idx] = 1'b1;
  end

  assign BUSY      = (state != IDLE);
  assign shreg_nxt = shreg_p0 << 1;

  // Stage p0: accepted word and a left-shifting copy that feeds SR_DATA.
  always_ff @(posedge CLK) begin
    if ((state == IDLE) && gnt_vld) begin
      word_p0  <= req_word;
      shreg_p0 <= req_word;
    end else if (state == SHIFT) begin
      shreg_p0 <= shreg_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt_p0   <= '0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      SR_LOAD  <= 1'b0;
      SR_DATA  <= 1'b0;
      DONE     <= 1'b0;
      DONE_ID  <= '0;
      MISMATCH <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      DONE_ID  <= '0;
      MISMATCH <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            state   <= SHIFT;
            gnt_p0  <= gnt_idx;
            ptr     <= rr_next(gnt_idx);
            bit_cnt <= '0;
            SR_LOAD <= 1'b1;
            SR_DATA <= req_word[WIDTH-1];
          end
        end
        SHIFT: begin
          // The register samples on every edge SR_LOAD is high; the last bit lands on this edge.
          if (bit_cnt == BIT_LAST) begin
            state   <= CHECK;
            SR_LOAD <= 1'b0;
            SR_DATA <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
            SR_DATA <= shreg_nxt[WIDTH-1];
          end
        end
        CHECK: begin
          DONE     <= 1'b1;
          DONE_ID  <= gnt_p0;
          MISMATCH <= (SR_Q != word_p0);
          hold_cnt <= '0;
          state    <= (HOLD_CYCLES > 0) ? HOLD : IDLE;
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST)
            state <= IDLE;
          else
            hold_cnt <= hold_cnt + HCW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_load_sequencer.sv
// Randomised scoreboard bench for shift_load_sequencer with a behavioural shift-register model.
module tb_shift_load_sequencer;

  localparam int W   = 4;
  localparam int N   = 2;
  localparam int H   = 2;
  localparam int IDW = 1;

  logic           CLK = 1'b0;
  logic           RESET_B;
  logic [N-1:0]   REQ_VALID;
  logic [N*W-1:0] REQ_DATA;
  logic [N-1:0]   REQ_READY;
  logic           SR_LOAD, SR_DATA;
  logic [W-1:0]   SR_Q;
  logic           DONE;
  logic [IDW-1:0] DONE_ID;
  logic           MISMATCH, BUSY;

  logic [W-1:0]   sr_reg;
  logic           corrupt_on = 1'b0;

  logic [N-1:0]   rdy_h0;
  logic           load_h0, data_h0, done_h0, mm_h0, busy_h0;
  logic [IDW-1:0] id_h0;
  logic [W-1:0]   sr_h0;

  typedef struct {
    int           id;
    logic [W-1:0] word;
    bit           mism;
    int           done_edge;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           edge_cnt = 0;
  int           ptr_m = 0;
  int           next_ok = 0;
  int           last_g = -1;
  int           last_edge = 0;
  int           rate = 0;
  bit           drop_en = 0;
  bit           cmode = 0;
  bit           force_c = 0;
  logic [N-1:0] pend = '0;
  logic [W-1:0] pdata[N];

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  // Serial-in register: shifts toward the MSB, new bit enters at bit 0.
  always_ff @(posedge CLK or negedge RESET_B)
    if (!RESET_B) sr_reg <= '0;
    else if (SR_LOAD) sr_reg <= {sr_reg[W-2:0], SR_DATA};

  always_ff @(posedge CLK or negedge RESET_B)
    if (!RESET_B) sr_h0 <= '0;
    else if (load_h0) sr_h0 <= {sr_h0[W-2:0], data_h0};

  assign SR_Q = corrupt_on ? '0 : sr_reg;

  shift_load_sequencer #(.WIDTH(W), .NREQ(N), .HOLD_CYCLES(H)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_READY(REQ_READY), .SR_LOAD(SR_LOAD), .SR_DATA(SR_DATA), .SR_Q(SR_Q),
    .DONE(DONE), .DONE_ID(DONE_ID), .MISMATCH(MISMATCH), .BUSY(BUSY)
  );

  shift_load_sequencer #(.WIDTH(W), .NREQ(N), .HOLD_CYCLES(0)) dut_h0 (
    .CLK(CLK), .RESET_B(RESET_B), .REQ_VALID(2'b01), .REQ_DATA(8'h0A),
    .REQ_READY(rdy_h0), .SR_LOAD(load_h0), .SR_DATA(data_h0), .SR_Q(sr_h0),
    .DONE(done_h0), .DONE_ID(id_h0), .MISMATCH(mm_h0), .BUSY(busy_h0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    REQ_VALID = pend;
    for (int i = 0; i < N; i++) REQ_DATA[i*W +: W] = pdata[i];
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && rate > 0 && $urandom_range(0, 99) < rate) begin
        pend[i]  = 1'b1;
        pdata[i] = W'($urandom);
      end else if (pend[i] && drop_en && $urandom_range(0, 99) < 4) begin
        pend[i] = 1'b0;
      end
    end
    apply_inputs();
  endtask

  // One clock: predict grant from the round-robin rule, then commit it after the edge.
  task automatic step();
    int           g;
    int           n;
    logic [N-1:0] exp_rdy;
    bit           cflag;
    exp_t         e;
    @(negedge CLK);
    n = edge_cnt;
    g = -1;
    exp_rdy = '0;
    if (n + 1 >= next_ok)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr_m + k) % N;
        if (g < 0 && pend[i]) g = i;
      end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("busy", 64'(BUSY), 64'(n + 1 < next_ok));
    chk("req_ready", 64'(REQ_READY), 64'(exp_rdy));
    @(posedge CLK);
    #1;
    last_g = g;
    if (g >= 0) begin
      cflag       = force_c || (cmode && $urandom_range(0, 3) == 0);
      e.id        = g;
      e.word      = pdata[g];
      e.mism      = cflag && (pdata[g] != '0);
      e.done_edge = n + 1 + W + 1;
      sb.push_back(e);
      ptr_m      = (g + 1) % N;
      next_ok    = n + 1 + W + 2 + H;
      last_edge  = n + 1;
      corrupt_on = cflag;
      pend[g]    = 1'b0;
    end
    drive();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 64'(REQ_READY), 64'(0));
    chk("rst_sr_load", 64'(SR_LOAD), 64'(0));
    chk("rst_sr_data", 64'(SR_DATA), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_done_id", 64'(DONE_ID), 64'(0));
    chk("rst_mismatch", 64'(MISMATCH), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
  endtask

  task automatic wait_accept(input string name);
    for (int t = 0; t < 40; t++) begin
      step();
      if (last_g >= 0) break;
    end
    chk(name, 64'(last_g >= 0), 64'(1));
  endtask

  // Monitor: pop the expected completion whenever DONE is presented.
  initial begin : monitor
    int   load_cnt;
    exp_t e;
    load_cnt = 0;
    forever begin
      @(negedge CLK);
      if (RESET_B !== 1'b1) begin
        load_cnt = 0;
      end else begin
        if (SR_LOAD) load_cnt++;
        if (DONE) begin
          if (sb.size() == 0) begin
            chk("done_unexpected", 64'(1), 64'(0));
          end else begin
            e = sb.pop_front();
            chk("done_id", 64'(DONE_ID), 64'(e.id));
            chk("done_mismatch", 64'(MISMATCH), 64'(e.mism));
            chk("done_time", 64'(edge_cnt), 64'(e.done_edge));
            chk("sr_word", 64'(sr_reg), 64'(e.word));
            chk("load_cycles", 64'(load_cnt), 64'(W));
          end
          load_cnt = 0;
        end else begin
          chk("idle_flags", 64'({DONE_ID, MISMATCH}), 64'(0));
        end
      end
    end
  end

  // Zero-hold instance with requester 0 permanently valid.
  initial begin : h0_check
    int prev_acc;
    int acc;
    int low_run;
    bit seen_high;
    prev_acc = -1; acc = 0; low_run = 0; seen_high = 0;
    wait (RESET_B === 1'b1);
    repeat (60) begin
      @(negedge CLK);
      if (rdy_h0[0]) begin
        if (prev_acc >= 0) chk("h0_spacing", 64'(edge_cnt + 1 - prev_acc), 64'(W + 2));
        prev_acc = edge_cnt + 1;
        acc++;
      end
      if (load_h0) begin
        if (seen_high && low_run > 0) chk("h0_load_gap", 64'(low_run), 64'(2));
        seen_high = 1;
        low_run   = 0;
      end else begin
        low_run++;
      end
      if (done_h0) chk("h0_mismatch", 64'(mm_h0), 64'(0));
    end
    chk("h0_accepts", 64'(acc >= 8), 64'(1));
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin : main
    logic [W-1:0] w;
    int           acc;
    int           prev;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    RESET_B = 1'b0;
    pend    = '1;
    apply_inputs();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs();
    pend = '0;
    apply_inputs();
    RESET_B = 1'b1;

    // Single requester, known word, bit order on the serial pins.
    w = 4'b1011;
    pend[0] = 1'b1; pdata[0] = w;
    apply_inputs();
    wait_accept("t2_accept");
    chk("t2_grant", 64'(last_g), 64'(0));
    for (int k = 0; k < W; k++) begin
      @(negedge CLK);
      chk("t2_sr_load", 64'(SR_LOAD), 64'(1));
      chk("t2_sr_data", 64'(SR_DATA), 64'(w[W-1-k]));
    end
    step();

    // Requester 1 with a corrupted readback.
    pend[1] = 1'b1; pdata[1] = 4'b0110; force_c = 1;
    apply_inputs();
    wait_accept("t4_accept");
    chk("t4_grant", 64'(last_g), 64'(1));
    force_c = 0;

    // Both requesters held valid: alternating grants at the minimum spacing.
    pend = '1;
    apply_inputs();
    rate = 100;
    acc = 0; prev = -1;
    for (int t = 0; t < 80 && acc < 4; t++) begin
      step();
      if (last_g >= 0) begin
        chk("t3_grant_seq", 64'(last_g), 64'(acc % 2));
        if (prev >= 0) chk("t3_spacing", 64'(last_edge - prev), 64'(W + 2 + H));
        prev = last_edge;
        acc++;
      end
    end
    chk("t3_accepts", 64'(acc), 64'(4));

    // Random traffic with drops and corrupted readbacks.
    rate = 40; drop_en = 1; cmode = 1;
    repeat (250) step();
    rate = 0; drop_en = 0; cmode = 0;
    repeat (40) step();
    chk("drain_pend", 64'(pend), 64'(0));

    // Reset in the middle of a shift with requester 1 pending.
    pend = '1;
    pdata[0] = W'($urandom); pdata[1] = W'($urandom);
    apply_inputs();
    wait_accept("t5_accept");
    pend[1] = 1'b1;
    apply_inputs();
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RESET_B = 1'b0;
    #1;
    chk_reset_outputs();
    sb.delete();
    ptr_m = 0; next_ok = 0;
    @(posedge CLK);
    #1;
    RESET_B = 1'b1;
    pend = '1;
    pdata[0] = W'($urandom);
    apply_inputs();
    step();
    chk("t5_first_grant", 64'(last_g), 64'(0));
    repeat (30) step();
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
